// File: rtl/router_pkt_fifo.sv
// Packet-aware channel FIFO: stores {header marker, data}, tracks packet length on read, flags parity word and framing errors.
// Read data 1-cycle latency; writes when full are dropped; optional occupancy port under ROUTER_FIFO_LEVEL_EN.
module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int LEN_W     = 6,
  parameter int AF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_last,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic              pkt_err
`ifdef ROUTER_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0]    ptr_t;
  typedef logic [LEN_W:0] rem_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t FULL_LVL = ptr_t'(DEPTH);
  localparam ptr_t AF_LVL   = ptr_t'(DEPTH - AF_MARGIN);
  localparam rem_t REM_ONE  = rem_t'(1);

  logic [DATA_W:0]   mem [DEPTH];
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  ptr_t              occ;
  rem_t              pkt_rem_q, pkt_rem_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_last_q, rd_last_d;
  logic              pkt_err_q, pkt_err_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W:0]   rd_word;
  logic              rd_hdr;
  logic [LEN_W-1:0]  rd_len;

  // Extra pointer MSB makes the difference range 0..DEPTH unambiguous.
  assign occ         = wr_ptr_q - rd_ptr_q;
  assign full        = (occ == FULL_LVL);
  assign empty       = (occ == '0);
  assign almost_full = (occ >= AF_LVL);

  assign wr_acc  = write_enb && !full && !soft_reset;
  assign rd_acc  = read_enb && !empty && !soft_reset;
  assign rd_word = mem[rd_ptr_q[AW-1:0]];
  assign rd_hdr  = rd_word[DATA_W];
  assign rd_len  = rd_word[DATA_W-1 -: LEN_W];

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_rem_d  = pkt_rem_q;
    data_out_d = data_out_q;
    rd_last_d  = rd_last_q;
    pkt_err_d  = pkt_err_q;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_rem_d  = '0;
      data_out_d = '0;
      rd_last_d  = 1'b0;
      pkt_err_d  = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        data_out_d = rd_word[DATA_W-1:0];
        rd_last_d  = 1'b0;
        if (rd_hdr) begin
          // A header arriving before the previous packet finished means truncation.
          pkt_rem_d = {1'b0, rd_len} + REM_ONE;
          if (pkt_rem_q != '0) pkt_err_d = 1'b1;
        end else if (pkt_rem_q != '0) begin
          pkt_rem_d = pkt_rem_q - REM_ONE;
          rd_last_d = (pkt_rem_q == REM_ONE);
        end else begin
          pkt_err_d = 1'b1;
        end
      end else if (pkt_rem_q == '0) begin
        data_out_d = '0;
        rd_last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_rem_q  <= '0;
      data_out_q <= '0;
      rd_last_q  <= 1'b0;
      pkt_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_rem_q  <= pkt_rem_d;
      data_out_q <= data_out_d;
      rd_last_q  <= rd_last_d;
      pkt_err_q  <= pkt_err_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_last  = rd_last_q;
  assign pkt_err  = pkt_err_q;

`ifdef ROUTER_FIFO_LEVEL_EN
  ptr_t level_q, level_d;

  assign level_d = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) level_q <= '0;
    else         level_q <= level_d;
  end

  assign level = level_q;
`endif

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Parametrised, packet-aware output FIFO for the router's per-destination channels; next generation of the fixed 16x8 channel FIFO.
- Each entry stores a data word plus a header-marker bit (taken from lfd_state).
- Read side tracks the current packet from the header's length field, flags the parity word and reports framing errors.
- Sits between the router register/FSM and a destination read port.

Parameters:
DATA_W, 8, data word width in bits; must be ≥ LEN_W+1.
DEPTH, 16, number of entries; power of two, ≥ 4.
LEN_W, 6, payload-length field width; the field is header bits [DATA_W-1 : DATA_W-LEN_W].
AF_MARGIN, 2, almost_full asserts when level ≥ DEPTH-AF_MARGIN.

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
soft_reset  in  1  synchronous clear (channel time-out)
write_enb  in  1  write request
lfd_state  in  1  current write word is a packet header
data_in  in  DATA_W  write data
read_enb  in  1  read request
data_out  out  DATA_W  registered read data
rd_last  out  1  data_out holds the last (parity) word of a packet
full  out  1  level == DEPTH
almost_full  out  1  level ≥ DEPTH-AF_MARGIN
empty  out  1  level == 0
pkt_err  out  1  sticky framing error

Behaviour:
- Reset (resetn=0, asynchronous): pointers=0, pkt_rem=0, data_out=0, rd_last=0, pkt_err=0, empty=1, full=0, almost_full=0. Memory contents are don't-care.
- Storage: DEPTH x (DATA_W+1) words holding {lfd_state, data_in}.
- Pointers: log2(DEPTH)+1 bits each. Extra MSB distinguishes full from empty. Wrap is natural modulo 2·DEPTH.
- full, empty and almost_full are combinational from the registered pointers. Level = wr_ptr - rd_ptr.
- Write accepted iff write_enb && !full. A write attempted while full is dropped silently, even with a simultaneous read.
- Read accepted iff read_enb && !empty. data_out is updated at the next edge, giving 1-cycle read latency.
- Simultaneous accepted read and write: both pointers advance and level is unchanged. Allowed whenever not empty and not full.
- Packet tracking, on each accepted read:
  - Marker bit = 1: pkt_rem <= len_field + 1 (payload + parity). If pkt_rem was nonzero, set pkt_err (truncated previous packet).
  - Marker bit = 0 and pkt_rem > 0: pkt_rem decrements.
  - Marker bit = 0 and pkt_rem == 0: set pkt_err (orphan word). The word is still output.
- rd_last is registered alongside data_out. It is 1 exactly when the accepted read is a non-header word taking pkt_rem 1→0; otherwise 0.
- Header with len_field=0: pkt_rem=1, and the next word is the parity word with rd_last=1.
- data_out idle rule: if no read is accepted and pkt_rem==0, data_out <= 0 and rd_last <= 0. Otherwise data_out holds.
  - Consequence: parity read on edge N, no read on edge N+1 → data_out=parity after N, 0 after N+1.
- soft_reset=1 at an edge:
  - Clears pointers, pkt_rem, data_out, rd_last and pkt_err.
  - Overrides any write or read in the same cycle.
  - Packet data mid-flight is discarded.
- resetn asserted mid-packet behaves the same as soft_reset, but asynchronously.
- pkt_rem width is LEN_W+1 bits, so len_field+1 never overflows.

Optional Feature:
ROUTER_FIFO_LEVEL_EN
- Defined: adds output port level [log2(DEPTH):0], the registered occupancy (0..DEPTH). It is 0 on reset and soft_reset and updates on the same edge as the pointers.
- Undefined: the port and its register are absent. full, empty and almost_full are derived from the pointers only. Behaviour is otherwise identical.

Test Plan:
- resetn pulse low → empty=1, full=0, data_out=0, rd_last=0, pkt_err=0 immediately, without waiting for a clock edge.
- Defaults; write header 8'h39 (len 14, addr 01) with lfd_state=1, payload 0..13, random parity (16 words), then read 16 → data_out sequence 39,00..0D,parity; rd_last=1 only with parity; data_out=0 one cycle after reads stop; full=1 after the 16th write, almost_full=1 from the 14th.
- Write a 17th word while full → dropped, level stays 16. Read+write together when full → write dropped, level 15. Read+write together at level 8 → level stays 8.
- Header 8'h00 (len 0) + parity → read gives 00 then parity with rd_last=1. Repeat across pointer wrap (≥3 full packets) → order preserved, no spurious full/empty.
- soft_reset after 5 words read of a 16-word packet → next edge empty=1, data_out=0, pkt_rem=0. A subsequent new packet reads back cleanly with pkt_err=0.
- Write a non-header word into empty FIFO and read it → pkt_err=1 and sticky. New header while pkt_rem=3 → pkt_err stays 1. soft_reset clears it.
